n64adv2_apu_fir_sched: RTL

N64ADV2_APU_FIR_SCHED -- requirements
Module: n64adv2_apu_fir_sched

---
 rtl/n64adv2_apu_fir_sched.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/n64adv2_apu_fir_sched.sv
// Time-shares one FIR between left and right audio channels.
// Sends L then R as one SOP/EOP packet and regroups the filtered pair.
module n64adv2_apu_fir_sched #(
  parameter int IW      = 16,
  parameter int OW      = 24,
  parameter int GAP_CYC = 1
) (
  input  logic          AMCLK_i,
  input  logic          nARST,
  input  logic [IW-1:0] APDATA_LEFT_i,
  input  logic [IW-1:0] APDATA_RIGHT_i,
  input  logic          APDATA_VALID_i,
  output logic [IW-1:0] SINK_DATA_o,
  output logic          SINK_VALID_o,
  output logic          SINK_SOP_o,
  output logic          SINK_EOP_o,
  input  logic [OW-1:0] SOURCE_DATA_i,
  input  logic          SOURCE_VALID_i,
  input  logic          SOURCE_SOP_i,
  input  logic          SOURCE_EOP_i,
  output logic [OW-1:0] APDATA_LEFT_o,
  output logic [OW-1:0] APDATA_RIGHT_o,
  output logic          APDATA_VALID_o,
  input  logic          CLR_FLAGS_i,
  output logic          OVERRUN_o,
  output logic          PROTO_ERR_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND_L,
    S_SEND_R,
    S_GAP
  } state_t;

  localparam logic [3:0] GAP_LD =
    (GAP_CYC > 0) ? 4'(GAP_CYC - 1) : 4'd0;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_gap;
  logic [3:0]    w_gap_nxt;
  logic          r_buf_full;
  logic [IW-1:0] r_buf_l;
  logic [IW-1:0] r_buf_r;
  logic [IW-1:0] r_cur_r;
  logic          w_consume;
  logic [IW-1:0] w_sdata;
  logic          w_svalid;
  logic          w_ssop;
  logic          w_seop;
  logic          w_ovr_set;

  logic [OW-1:0] r_hold;
  logic          r_got_left;
  logic          w_src_l;
  logic          w_src_r;
  logic          w_perr_set;

  // Sink outputs are registered from the next state, so they track it.
  always_comb begin
    w_next    = r_state;
    w_gap_nxt = r_gap;
    w_consume = 1'b0;
    w_sdata   = SINK_DATA_o;
    w_svalid  = 1'b0;
    w_ssop    = 1'b0;
    w_seop    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_buf_full) begin
          w_next    = S_SEND_L;
          w_consume = 1'b1;
          w_sdata   = r_buf_l;
          w_svalid  = 1'b1;
          w_ssop    = 1'b1;
        end
      end
      S_SEND_L: begin
        w_next   = S_SEND_R;
        w_sdata  = r_cur_r;
        w_svalid = 1'b1;
        w_seop   = 1'b1;
      end
      S_SEND_R: begin
        if (GAP_CYC == 0) begin
          w_next = S_IDLE;
        end else begin
          w_next    = S_GAP;
          w_gap_nxt = GAP_LD;
        end
      end
      S_GAP: begin
        if (r_gap == 4'd0) w_next = S_IDLE;
        else w_gap_nxt = r_gap - 4'd1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_ovr_set = APDATA_VALID_i & r_buf_full & ~w_consume;

  always_ff @(posedge AMCLK_i) begin
    if (!nARST) begin
      r_state <= S_IDLE;
      r_gap   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_gap   <= w_gap_nxt;
    end
  end

  always_ff @(posedge AMCLK_i) begin
    if (!nARST) begin
      r_buf_full   <= 1'b0;
      r_buf_l      <= '0;
      r_buf_r      <= '0;
      r_cur_r      <= '0;
      SINK_DATA_o  <= '0;
      SINK_VALID_o <= 1'b0;
      SINK_SOP_o   <= 1'b0;
      SINK_EOP_o   <= 1'b0;
    end else begin
      if (APDATA_VALID_i && (!r_buf_full || w_consume)) begin
        r_buf_full <= 1'b1;
        r_buf_l    <= APDATA_LEFT_i;
        r_buf_r    <= APDATA_RIGHT_i;
      end else if (w_consume) begin
        r_buf_full <= 1'b0;
      end
      // Right word is latched so a refill on the consume edge is safe.
      if (w_consume) r_cur_r <= r_buf_r;
      SINK_DATA_o  <= w_sdata;
      SINK_VALID_o <= w_svalid;
      SINK_SOP_o   <= w_ssop;
      SINK_EOP_o   <= w_seop;
    end
  end

  assign w_src_l = SOURCE_VALID_i & SOURCE_SOP_i & ~SOURCE_EOP_i;
  assign w_src_r = SOURCE_VALID_i & SOURCE_EOP_i & ~SOURCE_SOP_i;
  assign w_perr_set =
    (w_src_l & r_got_left) |
    (w_src_r & ~r_got_left) |
    (SOURCE_VALID_i & (SOURCE_SOP_i ~^ SOURCE_EOP_i));

  always_ff @(posedge AMCLK_i) begin
    if (!nARST) begin
      r_hold         <= '0;
      r_got_left     <= 1'b0;
      APDATA_LEFT_o  <= '0;
      APDATA_RIGHT_o <= '0;
      APDATA_VALID_o <= 1'b0;
      OVERRUN_o      <= 1'b0;
      PROTO_ERR_o    <= 1'b0;
    end else begin
      APDATA_VALID_o <= 1'b0;
      if (w_src_l) begin
        r_hold     <= SOURCE_DATA_i;
        r_got_left <= 1'b1;
      end else if (w_src_r && r_got_left) begin
        APDATA_LEFT_o  <= r_hold;
        APDATA_RIGHT_o <= SOURCE_DATA_i;
        APDATA_VALID_o <= 1'b1;
        r_got_left     <= 1'b0;
      end
      OVERRUN_o   <= w_ovr_set | (OVERRUN_o & ~CLR_FLAGS_i);
      PROTO_ERR_o <= w_perr_set | (PROTO_ERR_o & ~CLR_FLAGS_i);
    end
  end

endmodule
